ntt_stream_gearbox: RTL and testbench

//   Parametrised serial<->parallel I/O adapter around the NTT datapath cores.

---
 rtl/ntt_stream_gearbox.sv | 151 +++++++++++++++
 tb/tb_ntt_stream_gearbox.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stream_gearbox.sv
// Serial<->parallel gearbox for the NTT cores: packs ingress words into LANES-wide vectors
// and unpacks core vectors through a two-entry ping-pong buffer into a valid/ready word stream.
module ntt_stream_gearbox #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic                          s_start,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          par_out_valid,
    output logic                          par_out_start,
    output logic [LANES*DATA_WIDTH-1:0]   par_out_data,
    input  logic                          par_in_valid,
    input  logic                          par_in_start,
    input  logic [LANES*DATA_WIDTH-1:0]   par_in_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_data,
    input  logic                          clr_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int CNT_W = $clog2(LANES);
    localparam int VEC_W = LANES * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] lane_p0 [LANES];
    logic [CNT_W-1:0]      cnt_p0;
    logic                  start_tag_p0;
    logic                  misalign;
    logic                  last_word;
    logic [CNT_W-1:0]      wr_lane;
    logic [VEC_W-1:0]      vec_next;

    // A start tag seen mid-vector restarts assembly with this word as lane 0.
    assign misalign  = s_valid && s_start && (cnt_p0 != '0);
    assign last_word = s_valid && !misalign && (cnt_p0 == CNT_W'(LANES - 1));
    assign wr_lane   = misalign ? '0 : cnt_p0;

    always_ff @(posedge clk) begin
        if (s_valid) begin
            lane_p0[wr_lane] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0       <= '0;
            start_tag_p0 <= 1'b0;
        end else if (s_valid) begin
            if (misalign) begin
                cnt_p0       <= CNT_W'(1);
                start_tag_p0 <= 1'b1;
            end else begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
                if (cnt_p0 == '0) begin
                    start_tag_p0 <= s_start;
                end
            end
        end
    end

    always_comb begin
        vec_next = '0;
        for (int i = 0; i < LANES; i++) begin
            vec_next[i*DATA_WIDTH +: DATA_WIDTH] = lane_p0[i];
        end
        vec_next[VEC_W-1 -: DATA_WIDTH] = s_data;
    end

    // ---- ingress p0 -> p1: publish the completed vector ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out_valid <= 1'b0;
            par_out_start <= 1'b0;
            par_out_data  <= '0;
        end else begin
            par_out_valid <= last_word;
            if (last_word) begin
                par_out_start <= start_tag_p0;
                par_out_data  <= vec_next;
            end
        end
    end

    logic [VEC_W-1:0]      vec_buf [2];
    logic [1:0]            full;
    logic [1:0]            tag;
    logic                  rd_sel;
    logic                  wr_sel;
    logic [CNT_W-1:0]      idx;
    logic                  drain;
    logic                  pop;
    logic                  slot_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rd_word;

    assign drain     = full[rd_sel] && m_ready;
    assign pop       = drain && (idx == CNT_W'(LANES - 1));
    // The slot being emptied this cycle may be refilled in the same cycle.
    assign slot_free = !full[wr_sel] || (pop && (rd_sel == wr_sel));
    assign accept    = par_in_valid && slot_free;

    always_ff @(posedge clk) begin
        if (accept) begin
            vec_buf[wr_sel] <= par_in_data;
        end
    end

    // ---- egress buffer -> word stream ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= '0;
            tag    <= '0;
            rd_sel <= 1'b0;
            wr_sel <= 1'b0;
            idx    <= '0;
        end else begin
            if (drain) begin
                idx <= idx + CNT_W'(1);
                if (pop) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end
            end
            if (accept) begin
                full[wr_sel] <= 1'b1;
                tag[wr_sel]  <= par_in_start;
                wr_sel       <= ~wr_sel;
            end
        end
    end

    assign rd_word = vec_buf[rd_sel][int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign m_valid = full[rd_sel];
    assign m_data  = m_valid ? rd_word : '0;
    assign m_start = tag[rd_sel] && (idx == '0) && m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= (frame_err && !clr_err) || misalign;
            overflow  <= (overflow && !clr_err) || (par_in_valid && !slot_free);
        end
    end

endmodule

// File: tb/tb_ntt_stream_gearbox.sv
// Bench for ntt_stream_gearbox: directed table/sequence checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_ntt_stream_gearbox;
    localparam int DW    = 32;
    localparam int LANES = 32;
    localparam int VW    = DW * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_start;
    logic [DW-1:0] s_data;
    logic          par_out_valid, par_out_start;
    logic [VW-1:0] par_out_data;
    logic          par_in_valid, par_in_start;
    logic [VW-1:0] par_in_data;
    logic          m_valid, m_ready, m_start;
    logic [DW-1:0] m_data;
    logic          clr_err, frame_err, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ntt_stream_gearbox #(.DATA_WIDTH(DW), .LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_start(s_start), .s_data(s_data),
        .par_out_valid(par_out_valid), .par_out_start(par_out_start), .par_out_data(par_out_data),
        .par_in_valid(par_in_valid), .par_in_start(par_in_start), .par_in_data(par_in_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_start(m_start), .m_data(m_data),
        .clr_err(clr_err), .frame_err(frame_err), .overflow(overflow)
    );

    // Reference model state: words of the vector being assembled, and stored egress vectors.
    logic [DW-1:0] part[$];
    bit            ptag;
    bit            exp_pvld, exp_pstart;
    logic [VW-1:0] exp_pdata;
    logic [VW-1:0] vq[$];
    bit            tq[$];
    int            pos;
    bit            exp_ferr, exp_ovf;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkd(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int i = 0; i < LANES; i++)
            if (bad < 0 && act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s lane %0d: got %0h expected %0h", name, bad,
                     act[bad*DW +: DW], exp[bad*DW +: DW]);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(int base);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'(base + i);
        return v;
    endfunction

    task automatic model_reset();
        part.delete(); vq.delete(); tq.delete();
        ptag = 0; pos = 0; exp_pvld = 0; exp_pstart = 0; exp_pdata = '0;
        exp_ferr = 0; exp_ovf = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit ferr_ev, ovf_ev, has, pop, free;
        ferr_ev = 0; ovf_ev = 0;
        if (rst) begin
            model_reset();
        end else begin
            exp_pvld = 0;
            if (s_valid) begin
                if (s_start && part.size() != 0) begin
                    part.delete();
                    ferr_ev = 1;
                end
                if (part.size() == 0) ptag = s_start;
                part.push_back(s_data);
                if (part.size() == LANES) begin
                    for (int i = 0; i < LANES; i++) exp_pdata[i*DW +: DW] = part[i];
                    exp_pstart = ptag;
                    exp_pvld = 1;
                    part.delete();
                end
            end
            has  = vq.size() > 0;
            pop  = has && m_ready && pos == LANES - 1;
            free = vq.size() < 2 || pop;
            if (has && m_ready) begin
                if (pos == LANES - 1) begin
                    pos = 0;
                    void'(vq.pop_front());
                    void'(tq.pop_front());
                end else begin
                    pos++;
                end
            end
            if (par_in_valid) begin
                if (free) begin
                    vq.push_back(par_in_data);
                    tq.push_back(par_in_start);
                end else begin
                    ovf_ev = 1;
                end
            end
            if (clr_err) begin
                exp_ferr = 0;
                exp_ovf = 0;
            end
            exp_ferr = exp_ferr | ferr_ev;
            exp_ovf  = exp_ovf | ovf_ev;
        end
    endtask

    task automatic compare_all();
        chk1("par_out_valid", par_out_valid, exp_pvld);
        if (exp_pvld) chk1("par_out_start", par_out_start, exp_pstart);
        chk_vec("par_out_data", par_out_data, exp_pdata);
        chk1("m_valid", m_valid, vq.size() > 0);
        if (vq.size() > 0) begin
            chkd("m_data", m_data, vq[0][pos*DW +: DW]);
            chk1("m_start", m_start, tq[0] && pos == 0);
        end else begin
            chk1("m_start_idle", m_start, 1'b0);
        end
        chk1("frame_err", frame_err, exp_ferr);
        chk1("overflow", overflow, exp_ovf);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        s_valid = 0; s_start = 0; s_data = '0;
        par_in_valid = 0; par_in_start = 0; par_in_data = '0;
        clr_err = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    typedef struct {
        int pre;
        int base;
        bit start;
        bit exp_start;
        bit exp_err;
        int exp_lane0;
        int exp_last;
    } ing_case_t;

    ing_case_t tab[4];

    initial begin
        tab[0] = '{0,    0,    1'b1, 1'b1, 1'b0,    0,   31};
        tab[1] = '{10,   500,  1'b1, 1'b1, 1'b1,  500,  531};
        tab[2] = '{0,    1000, 1'b0, 1'b0, 1'b0, 1000, 1031};
        tab[3] = '{31,   2000, 1'b1, 1'b1, 1'b1, 2000, 2031};

        model_reset();
        idle();
        m_ready = 1;
        do_reset();

        // Ingress packing / misalignment table
        for (int r = 0; r < 4; r++) begin
            idle();
            do_reset();
            for (int k = 0; k < tab[r].pre; k++) begin
                s_valid = 1; s_start = (k == 0); s_data = DW'(900 + k);
                cycle();
            end
            for (int k = 0; k < LANES; k++) begin
                s_valid = 1; s_start = tab[r].start && k == 0; s_data = DW'(tab[r].base + k);
                cycle();
            end
            idle();
            chk1("tab_pvalid", par_out_valid, 1'b1);
            chk1("tab_pstart", par_out_start, tab[r].exp_start);
            chkd("tab_lane0", par_out_data[DW-1:0], DW'(tab[r].exp_lane0));
            chkd("tab_last", par_out_data[VW-1 -: DW], DW'(tab[r].exp_last));
            chk_vec("tab_vec", par_out_data, mkvec(tab[r].base));
            chk1("tab_ferr", frame_err, tab[r].exp_err);
            cycle();
            chk1("tab_pulse_end", par_out_valid, 1'b0);
            chkd("tab_hold", par_out_data[DW-1:0], DW'(tab[r].exp_lane0));
        end

        // T1: asynchronous reset mid-stream
        m_ready = 0;
        for (int k = 0; k < 12; k++) begin
            s_valid = 1; s_start = (k == 0 || k == 5); s_data = DW'(k);
            cycle();
        end
        idle();
        par_in_valid = 1; par_in_start = 1; par_in_data = mkvec(50);
        cycle();
        idle();
        m_ready = 1;
        for (int k = 0; k < 5; k++) cycle();
        chk1("t1_pre_mvalid", m_valid, 1'b1);
        chk1("t1_pre_ferr", frame_err, 1'b1);
        #2 rst = 1;
        #1;
        chk1("t1_pvalid", par_out_valid, 1'b0);
        chk1("t1_pstart", par_out_start, 1'b0);
        chk_vec("t1_pdata", par_out_data, '0);
        chk1("t1_mvalid", m_valid, 1'b0);
        chk1("t1_mstart", m_start, 1'b0);
        chkd("t1_mdata", m_data, '0);
        chk1("t1_ferr", frame_err, 1'b0);
        chk1("t1_ovf", overflow, 1'b0);
        cycle();
        rst = 0;
        for (int k = 0; k < LANES; k++) begin
            s_valid = 1; s_start = (k == 0); s_data = DW'(3000 + k);
            cycle();
        end
        idle();
        chk1("t1_restart_pvalid", par_out_valid, 1'b1);
        chk_vec("t1_restart_vec", par_out_data, mkvec(3000));

        // T4: unpack one start-tagged vector
        par_in_valid = 1; par_in_start = 1; par_in_data = mkvec(100);
        cycle();
        idle();
        for (int k = 0; k < LANES; k++) begin
            chk1("t4_mvalid", m_valid, 1'b1);
            chkd("t4_mdata", m_data, DW'(100 + k));
            chk1("t4_mstart", m_start, k == 0);
            cycle();
        end
        chk1("t4_done", m_valid, 1'b0);

        // T5: backpressure, overflow on third vector, flag clear priority
        do_reset();
        m_ready = 0;
        for (int v = 0; v < 3; v++) begin
            par_in_valid = 1; par_in_start = (v == 0); par_in_data = mkvec(200 + 100 * v);
            cycle();
        end
        idle();
        chk1("t5_ovf", overflow, 1'b1);
        chkd("t5_head", m_data, DW'(200));
        clr_err = 1; par_in_valid = 1; par_in_data = mkvec(999);
        cycle();
        idle();
        chk1("t5_clr_vs_event", overflow, 1'b1);
        clr_err = 1;
        cycle();
        idle();
        chk1("t5_clr", overflow, 1'b0);
        m_ready = 1;
        for (int k = 0; k < 2 * LANES; k++) begin
            chk1("t5_mvalid", m_valid, 1'b1);
            chkd("t5_mdata", m_data, DW'(k < LANES ? 200 + k : 300 + k - LANES));
            cycle();
        end
        chk1("t5_done", m_valid, 1'b0);

        // T6: accept into the slot freed on the same cycle
        do_reset();
        m_ready = 0;
        for (int v = 0; v < 2; v++) begin
            par_in_valid = 1; par_in_start = 0; par_in_data = mkvec(600 + 100 * v);
            cycle();
        end
        idle();
        m_ready = 1;
        for (int k = 0; k < LANES; k++) begin
            par_in_valid = (k == LANES - 1); par_in_data = mkvec(800);
            chkd("t6_adata", m_data, DW'(600 + k));
            cycle();
        end
        idle();
        chk1("t6_ovf", overflow, 1'b0);
        for (int k = 0; k < 2 * LANES; k++) begin
            chk1("t6_mvalid", m_valid, 1'b1);
            chkd("t6_mdata", m_data, DW'(k < LANES ? 700 + k : 800 + k - LANES));
            cycle();
        end
        chk1("t6_done", m_valid, 1'b0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            s_valid      = ($urandom_range(3) != 0);
            s_start      = ($urandom_range(39) == 0);
            s_data       = $urandom;
            par_in_valid = ($urandom_range(39) == 0);
            par_in_start = ($urandom_range(1) == 1);
            for (int i = 0; i < LANES; i++) par_in_data[i*DW +: DW] = $urandom;
            m_ready      = ($urandom_range(3) != 0);
            clr_err      = ($urandom_range(99) == 0);
            rst          = ($urandom_range(999) == 0);
            cycle();
        end
        rst = 0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
